// File: rtl/vr_mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds the funct3 encodings, the FSM state type and small decode helpers
// used by vr_muldiv_unit and its testbench.
package vr_mdu_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

    // rs1 is treated as signed by every op except the fully unsigned ones.
    function automatic logic rs1_signed(input logic [2:0] funct3);
        return (funct3 != MDU_MULHU) && (funct3 != MDU_DIVU) && (funct3 != MDU_REMU);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] funct3);
        return (funct3 == MDU_MUL) || (funct3 == MDU_MULH) ||
               (funct3 == MDU_DIV) || (funct3 == MDU_REM);
    endfunction

endpackage

// File: rtl/vr_muldiv_unit_if.sv
// Request/response bundle between the execute stage and vr_muldiv_unit.
// master: issuing pipeline (drives IN_*, KILL, OUT_READY).
// slave : the unit (drives IN_READY, OUT_*, BUSY).
interface vr_muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [2:0]       IN_FUNCT3;
    logic [XLEN-1:0]  IN_RS1;
    logic [XLEN-1:0]  IN_RS2;
    logic [TAG_W-1:0] IN_TAG;
    logic             KILL;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [XLEN-1:0]  OUT_RESULT;
    logic [TAG_W-1:0] OUT_TAG;
    logic             BUSY;

    modport master (
        output IN_VALID, IN_FUNCT3, IN_RS1, IN_RS2, IN_TAG, KILL, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_RESULT, OUT_TAG, BUSY
    );

    modport slave (
        input  IN_VALID, IN_FUNCT3, IN_RS1, IN_RS2, IN_TAG, KILL, OUT_READY,
        output IN_READY, OUT_VALID, OUT_RESULT, OUT_TAG, BUSY
    );
endinterface

// File: rtl/vr_muldiv_step.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
// Ports:
//   div_mode : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_in   : 2*XLEN accumulator {high, low}
//   operand  : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_out  : accumulator after this iteration
// Multiply: high half accumulates, the whole register shifts right, the
// multiplier is consumed from bit 0 of the low half.
// Divide: high half is the partial remainder, low half shifts the dividend
// out of its MSB and the quotient bits in at its LSB.
module vr_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              div_mode,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    always_comb begin
        sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
        shifted = acc_in[2*XLEN-1:XLEN-1];
        fits    = (shifted >= {1'b0, operand});
        // When the subtraction fits, the true difference is below the divisor,
        // so the low XLEN bits of the modular difference are exact.
        diff    = shifted[XLEN-1:0] - operand;

        if (div_mode) begin
            if (fits) begin
                acc_out = {diff, acc_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {shifted[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/vr_muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle.
// Ports:
//   CLK, RST : clock and synchronous active-high reset
//   bus      : slave side of vr_muldiv_unit_if (request, kill, response, busy)
// Operands are converted to magnitudes at acceptance, XLEN iterations run in
// CALC, and the sign fix-up is applied when the last iteration is written to
// the output register. Divide-by-zero and signed overflow skip iteration.
module vr_muldiv_unit
    import vr_mdu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic           CLK,
    input  logic           RST,
    vr_muldiv_unit_if.slave bus
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t state, state_nxt;

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] step_out;
    logic [XLEN-1:0]   op_b;
    logic [2:0]        funct3_q;
    logic [TAG_W-1:0]  tag_q;
    logic              neg_q;
    logic              fast_q;
    logic [CNT_W-1:0]  count;
    logic [XLEN-1:0]   result;
    logic [TAG_W-1:0]  out_tag;

    logic              accept;
    logic              last;
    logic              sign1, sign2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, overflow, fast;
    logic [XLEN-1:0]   fast_val;
    logic              neg;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   final_res;

    // Accept-time decode of the raw request.
    always_comb begin
        sign1    = rs1_signed(bus.IN_FUNCT3) & bus.IN_RS1[XLEN-1];
        sign2    = rs2_signed(bus.IN_FUNCT3) & bus.IN_RS2[XLEN-1];
        mag1     = sign1 ? -bus.IN_RS1 : bus.IN_RS1;
        mag2     = sign2 ? -bus.IN_RS2 : bus.IN_RS2;
        div_zero = is_div(bus.IN_FUNCT3) && (bus.IN_RS2 == '0);
        overflow = ((bus.IN_FUNCT3 == MDU_DIV) || (bus.IN_FUNCT3 == MDU_REM)) &&
                   (bus.IN_RS1 == MIN_NEG) && (bus.IN_RS2 == '1);
        fast     = div_zero || overflow;
        // funct3[1] separates remainder ops from quotient ops.
        if (div_zero) begin
            fast_val = bus.IN_FUNCT3[1] ? bus.IN_RS1 : '1;
        end else begin
            fast_val = bus.IN_FUNCT3[1] ? '0 : bus.IN_RS1;
        end
        neg = (is_div(bus.IN_FUNCT3) && bus.IN_FUNCT3[1]) ? sign1 : (sign1 ^ sign2);
    end

    vr_muldiv_step #(.XLEN(XLEN)) u_step (
        .div_mode (is_div(funct3_q)),
        .acc_in   (acc),
        .operand  (op_b),
        .acc_out  (step_out)
    );

    assign last = (count == CNT_W'(XLEN - 1));

    // Sign fix-up applied to the final iteration's output.
    always_comb begin
        prod = neg_q ? -step_out : step_out;
        quo  = step_out[XLEN-1:0];
        rem  = step_out[2*XLEN-1:XLEN];
        case (funct3_q)
            MDU_MUL:                        final_res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              final_res = neg_q ? -quo : quo;
            default:                        final_res = neg_q ? -rem : rem;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.IN_READY  = (state == IDLE);
        bus.OUT_VALID = (state == DONE);
        bus.BUSY      = (state != IDLE);
        case (state)
            IDLE: begin
                if (bus.IN_VALID && !bus.KILL) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            // Fast-path ops also pass through CALC for one cycle, which gives
            // OUT_VALID one edge after acceptance and a 3-cycle interval.
            CALC: begin
                if (fast_q || last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.OUT_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.KILL) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc      <= '0;
            op_b     <= '0;
            funct3_q <= '0;
            tag_q    <= '0;
            neg_q    <= 1'b0;
            fast_q   <= 1'b0;
            count    <= '0;
            result   <= '0;
            out_tag  <= '0;
        end else if (accept) begin
            // A fast-path value is parked in the low half of the accumulator.
            acc      <= {{XLEN{1'b0}}, (fast ? fast_val : mag1)};
            op_b     <= mag2;
            funct3_q <= bus.IN_FUNCT3;
            tag_q    <= bus.IN_TAG;
            neg_q    <= neg;
            fast_q   <= fast;
            count    <= '0;
        end else if (state == CALC && !bus.KILL) begin
            if (fast_q) begin
                result  <= acc[XLEN-1:0];
                out_tag <= tag_q;
            end else begin
                acc   <= step_out;
                count <= count + 1'b1;
                if (last) begin
                    result  <= final_res;
                    out_tag <= tag_q;
                end
            end
        end
    end

    assign bus.OUT_RESULT = result;
    assign bus.OUT_TAG    = out_tag;

endmodule
